// File: rtl/seq_calculator_if.sv
// Command/result handshake bundle for seq_calculator.
// The slave modport is the calculator; the master modport is its decoder/writeback side.
interface seq_calculator_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_rem;
  logic             out_carry;
  logic             out_ovf;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_rem, out_carry, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_rem, out_carry, out_ovf, out_err
  );
endinterface

// File: rtl/seq_calculator.sv
// Handshaked unsigned ADD/SUB/MUL/DIV unit with a registered result and flags.
// ADD/SUB/MUL and divide-by-zero finish on the accept edge; DIV runs a restoring divider, one quotient bit per clock.
module seq_calculator #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_calculator_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_rem;
  logic             r_carry;
  logic             r_ovf;
  logic             r_err;

  logic             w_accept;
  logic             w_bZero;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic             w_addOvf;
  logic             w_subOvf;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_partNext;
  logic [WIDTH-1:0] w_quoNext;
  logic             w_divLast;

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_bZero  = (bus.in_b == '0);
  assign w_sum    = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign w_diff   = {1'b0, bus.in_a} - {1'b0, bus.in_b};
  assign w_prod   = {{WIDTH{1'b0}}, bus.in_a} * {{WIDTH{1'b0}}, bus.in_b};
  assign w_addOvf = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.in_a[WIDTH-1]);
  assign w_subOvf = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.in_a[WIDTH-1]);

  // The partial remainder is always below the divisor, so bit WIDTH of the trial difference is exactly the borrow.
  assign w_shift    = {r_part, r_dvd[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_dvs};
  assign w_qbit     = ~w_trial[WIDTH];
  assign w_partNext = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quoNext  = {r_quo[WIDTH-2:0], w_qbit};
  assign w_divLast  = (r_count == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = (bus.in_op == OP_DIV && !w_bZero) ? DIV_RUN : DONE;
      end
      DIV_RUN: begin
        if (w_divLast) w_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_part   <= '0;
      r_quo    <= '0;
      r_result <= '0;
      r_rem    <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_rem   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      case (bus.in_op)
        OP_ADD: begin
          r_result <= w_sum[WIDTH-1:0];
          r_carry  <= w_sum[WIDTH];
          r_ovf    <= w_addOvf;
        end
        OP_SUB: begin
          r_result <= w_diff[WIDTH-1:0];
          r_carry  <= w_diff[WIDTH];
          r_ovf    <= w_subOvf;
        end
        OP_MUL: begin
          r_result <= w_prod[WIDTH-1:0];
          r_ovf    <= |w_prod[2*WIDTH-1:WIDTH];
        end
        OP_DIV: begin
          r_result <= '0;
          r_err    <= w_bZero;
          r_dvd    <= bus.in_a;
          r_dvs    <= bus.in_b;
          r_part   <= '0;
          r_quo    <= '0;
          r_count  <= w_bZero ? '0 : CW'(WIDTH);
        end
      endcase
    end else if (r_state == DIV_RUN) begin
      r_dvd   <= {r_dvd[WIDTH-2:0], 1'b0};
      r_part  <= w_partNext;
      r_quo   <= w_quoNext;
      r_count <= r_count - CW'(1);
      if (w_divLast) begin
        r_result <= w_quoNext;
        r_rem    <= w_partNext;
      end
    end
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.out_result = r_result;
  assign bus.out_rem    = r_rem;
  assign bus.out_carry  = r_carry;
  assign bus.out_ovf    = r_ovf;
  assign bus.out_err    = r_err;
endmodule

// File: tb/tb_seq_calculator.sv
// Directed self-checking bench for seq_calculator: an 8-bit instance for the main scenarios
// and a 16-bit instance to exercise the width parameter.
module tb_seq_calculator;
  logic clk = 1'b0;
  logic rst_n;
  int   nCompared = 0;
  int   nMismatched = 0;

  always #5 clk = ~clk;

  seq_calculator_if #(.WIDTH(8))  bus8 ();
  seq_calculator_if #(.WIDTH(16)) bus16 ();

  seq_calculator #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  seq_calculator #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  task automatic sendCmd8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.in_op    = op;
    bus8.in_a     = a;
    bus8.in_b     = b;
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
  endtask

  // lat = number of edges after the accept edge before out_valid is seen; -1 if it never appears
  task automatic waitValid8(input int limit, output int lat, output bit sawReady);
    lat = -1;
    sawReady = 1'b0;
    for (int i = 0; i <= limit; i++) begin
      @(negedge clk);
      if (bus8.in_ready) sawReady = 1'b1;
      if (bus8.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic takeResult8;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1 bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nCompared++;
    if ({bus8.in_ready, bus8.out_valid} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL reset_hs: ready/valid got %b expected 10", {bus8.in_ready, bus8.out_valid});
    end
    nCompared++;
    if ({bus8.out_result, bus8.out_rem, bus8.out_carry, bus8.out_ovf, bus8.out_err} !== 19'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_data: got %h expected 0",
               {bus8.out_result, bus8.out_rem, bus8.out_carry, bus8.out_ovf, bus8.out_err});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alu;
    logic [1:0] opT [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    logic [7:0] aT  [7] = '{8'd200, 8'd100, 8'd255, 8'd5, 8'd100, 8'd16, 8'd15};
    logic [7:0] bT  [7] = '{8'd100, 8'd100, 8'd1, 8'd7, 8'd156, 8'd17, 8'd17};
    logic [7:0] rT  [7] = '{8'd44, 8'd200, 8'd0, 8'd254, 8'd200, 8'd16, 8'd255};
    logic [2:0] fT  [7] = '{3'b100, 3'b010, 3'b100, 3'b100, 3'b110, 3'b010, 3'b000};
    int lat;
    bit sawReady;
    logic [18:0] got;
    for (int i = 0; i < 7; i++) begin
      sendCmd8(opT[i], aT[i], bT[i]);
      waitValid8(4, lat, sawReady);
      nCompared++;
      if (lat !== 0) begin
        nMismatched++;
        $display("[TB] FAIL alu_latency[%0d]: got %0d expected 0", i, lat);
      end
      got = {bus8.out_result, bus8.out_rem, bus8.out_carry, bus8.out_ovf, bus8.out_err};
      nCompared++;
      if (got !== {rT[i], 8'd0, fT[i]}) begin
        nMismatched++;
        $display("[TB] FAIL alu_data[%0d]: got res=%0d rem=%0d cvo/err=%b expected res=%0d rem=0 flags=%b",
                 i, got[18:11], got[10:3], got[2:0], rT[i], fT[i]);
      end
      takeResult8();
    end
  endtask

  task automatic test_div;
    logic [7:0] aT [4] = '{8'd200, 8'd7, 8'd255, 8'd255};
    logic [7:0] bT [4] = '{8'd7, 8'd200, 8'd16, 8'd255};
    logic [7:0] qT [4] = '{8'd28, 8'd0, 8'd15, 8'd1};
    logic [7:0] mT [4] = '{8'd4, 8'd7, 8'd15, 8'd0};
    int lat;
    bit sawReady;
    logic [18:0] got;
    for (int i = 0; i < 4; i++) begin
      sendCmd8(2'd3, aT[i], bT[i]);
      waitValid8(20, lat, sawReady);
      nCompared++;
      if (lat !== 8) begin
        nMismatched++;
        $display("[TB] FAIL div_latency[%0d]: got %0d expected 8", i, lat);
      end
      nCompared++;
      if (sawReady !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL div_ready_low[%0d]: in_ready seen high while busy, expected low", i);
      end
      got = {bus8.out_result, bus8.out_rem, bus8.out_carry, bus8.out_ovf, bus8.out_err};
      nCompared++;
      if (got !== {qT[i], mT[i], 3'b000}) begin
        nMismatched++;
        $display("[TB] FAIL div_data[%0d]: got q=%0d r=%0d flags=%b expected q=%0d r=%0d flags=000",
                 i, got[18:11], got[10:3], got[2:0], qT[i], mT[i]);
      end
      takeResult8();
    end
  endtask

  task automatic test_div_zero_hold;
    int lat;
    bit sawReady;
    logic [20:0] got;
    sendCmd8(2'd3, 8'd9, 8'd0);
    waitValid8(4, lat, sawReady);
    nCompared++;
    if (lat !== 0) begin
      nMismatched++;
      $display("[TB] FAIL div0_latency: got %0d expected 0", lat);
    end
    bus8.in_valid = 1'b1;
    bus8.in_op    = 2'd0;
    bus8.in_a     = 8'd1;
    bus8.in_b     = 8'd1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      got = {bus8.out_valid, bus8.in_ready, bus8.out_result, bus8.out_rem,
             bus8.out_carry, bus8.out_ovf, bus8.out_err};
      nCompared++;
      if (got !== {1'b1, 1'b0, 8'd0, 8'd0, 3'b001}) begin
        nMismatched++;
        $display("[TB] FAIL div0_hold[%0d]: got %h expected %h", k, got, {1'b1, 1'b0, 8'd0, 8'd0, 3'b001});
      end
    end
    bus8.in_valid = 1'b0;
    takeResult8();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      nCompared++;
      if ({bus8.out_valid, bus8.in_ready} !== 2'b01) begin
        nMismatched++;
        $display("[TB] FAIL div0_no_ghost[%0d]: valid/ready got %b expected 01", k, {bus8.out_valid, bus8.in_ready});
      end
    end
  endtask

  task automatic test_reset_mid_div;
    int lat;
    bit sawReady;
    sendCmd8(2'd3, 8'd255, 8'd1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    nCompared++;
    if ({bus8.out_valid, bus8.in_ready} !== 2'b01) begin
      nMismatched++;
      $display("[TB] FAIL abort_hs: valid/ready got %b expected 01", {bus8.out_valid, bus8.in_ready});
    end
    nCompared++;
    if ({bus8.out_result, bus8.out_rem, bus8.out_err} !== 17'd0) begin
      nMismatched++;
      $display("[TB] FAIL abort_data: got %h expected 0", {bus8.out_result, bus8.out_rem, bus8.out_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    waitValid8(10, lat, sawReady);
    nCompared++;
    if (lat !== -1) begin
      nMismatched++;
      $display("[TB] FAIL abort_discard: stale result after %0d cycles, expected none", lat);
    end
    sendCmd8(2'd0, 8'd1, 8'd1);
    waitValid8(4, lat, sawReady);
    nCompared++;
    if ({bus8.out_result, bus8.out_carry, bus8.out_ovf, bus8.out_err} !== {8'd2, 3'b000} || lat !== 0) begin
      nMismatched++;
      $display("[TB] FAIL abort_then_add: got res=%0d flags=%b lat=%0d expected res=2 flags=000 lat=0",
               bus8.out_result, {bus8.out_carry, bus8.out_ovf, bus8.out_err}, lat);
    end
    takeResult8();
  endtask

  task automatic test_back_to_back;
    int lat;
    bit sawReady;
    sendCmd8(2'd3, 8'd100, 8'd9);
    waitValid8(20, lat, sawReady);
    nCompared++;
    if ({bus8.out_result, bus8.out_rem} !== {8'd11, 8'd1}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_div: got q=%0d r=%0d expected q=11 r=1", bus8.out_result, bus8.out_rem);
    end
    takeResult8();
    @(negedge clk);
    nCompared++;
    if ({bus8.out_valid, bus8.in_ready} !== 2'b01) begin
      nMismatched++;
      $display("[TB] FAIL b2b_ready: valid/ready got %b expected 01", {bus8.out_valid, bus8.in_ready});
    end
    bus8.in_valid = 1'b1;
    bus8.in_op    = 2'd0;
    bus8.in_a     = 8'd3;
    bus8.in_b     = 8'd4;
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    waitValid8(4, lat, sawReady);
    nCompared++;
    if ({bus8.out_result, bus8.out_rem, bus8.out_carry, bus8.out_ovf, bus8.out_err} !== {8'd7, 8'd0, 3'b000}
        || lat !== 0) begin
      nMismatched++;
      $display("[TB] FAIL b2b_add: got res=%0d rem=%0d lat=%0d expected res=7 rem=0 lat=0",
               bus8.out_result, bus8.out_rem, lat);
    end
    takeResult8();
  endtask

  task automatic test_width16;
    logic [1:0]  opT [5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd3};
    logic [15:0] aT  [5] = '{16'd60000, 16'd300, 16'd1000, 16'd50000, 16'd65535};
    logic [15:0] bT  [5] = '{16'd10000, 16'd300, 16'd3000, 16'd7, 16'd256};
    logic [15:0] rT  [5] = '{16'd4464, 16'd24464, 16'd63536, 16'd7142, 16'd255};
    logic [15:0] mT  [5] = '{16'd0, 16'd0, 16'd0, 16'd6, 16'd255};
    logic [2:0]  fT  [5] = '{3'b100, 3'b010, 3'b100, 3'b000, 3'b000};
    int          lT  [5] = '{0, 0, 0, 16, 16};
    int lat;
    logic [34:0] got;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus16.in_valid = 1'b1;
      bus16.in_op    = opT[i];
      bus16.in_a     = aT[i];
      bus16.in_b     = bT[i];
      @(posedge clk);
      #1 bus16.in_valid = 1'b0;
      lat = -1;
      for (int c = 0; c <= 30; c++) begin
        @(negedge clk);
        if (bus16.out_valid) begin
          lat = c;
          break;
        end
      end
      nCompared++;
      if (lat !== lT[i]) begin
        nMismatched++;
        $display("[TB] FAIL w16_latency[%0d]: got %0d expected %0d", i, lat, lT[i]);
      end
      got = {bus16.out_result, bus16.out_rem, bus16.out_carry, bus16.out_ovf, bus16.out_err};
      nCompared++;
      if (got !== {rT[i], mT[i], fT[i]}) begin
        nMismatched++;
        $display("[TB] FAIL w16_data[%0d]: got res=%0d rem=%0d flags=%b expected res=%0d rem=%0d flags=%b",
                 i, got[34:19], got[18:3], got[2:0], rT[i], mT[i], fT[i]);
      end
      bus16.out_ready = 1'b1;
      @(posedge clk);
      #1 bus16.out_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus8.in_valid   = 1'b0;
    bus8.in_op      = 2'd0;
    bus8.in_a       = 8'd0;
    bus8.in_b       = 8'd0;
    bus8.out_ready  = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.in_op     = 2'd0;
    bus16.in_a      = 16'd0;
    bus16.in_b      = 16'd0;
    bus16.out_ready = 1'b0;
    test_reset();
    test_alu();
    test_div();
    test_div_zero_hold();
    test_reset_mid_div();
    test_back_to_back();
    test_width16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
